// File: rtl/iob_bus_merge_pkg.sv
// Shared definitions for the instruction/data bus merge: FSM states,
// master indices and native-bus field widths.
package iob_bus_merge_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Master indices; also the encoding of the grant and last-grant flops
    localparam logic MST_IBUS = 1'b0;
    localparam logic MST_DBUS = 1'b1;

    // Request bundle width: valid + addr + wdata + wstrb
    function automatic int unsigned req_w(input int unsigned addr_w, input int unsigned data_w);
        return 1 + addr_w + data_w + data_w / 8;
    endfunction

    // Response bundle width: rdata + ready
    function automatic int unsigned resp_w(input int unsigned data_w);
        return data_w + 1;
    endfunction

endpackage

// File: rtl/iob_rr_arb2.sv
// Two-input round-robin arbiter. Holds the last-grant flop; on a tie the
// master not granted last wins. Reset leaves ibus as last grant so dbus
// wins the first tie.
module iob_rr_arb2
    import iob_bus_merge_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic ibus_req_i,
    input  logic dbus_req_i,
    input  logic update_i,
    output logic grant_o
);

    logic last_q;
    logic last_d;

    // Winner selection from the current requests and the last grant
    always_comb begin
        if (ibus_req_i && dbus_req_i) begin
            grant_o = ~last_q;
        end else if (dbus_req_i) begin
            grant_o = MST_DBUS;
        end else begin
            grant_o = MST_IBUS;
        end
    end

    // Remember the winner whenever a grant is actually taken
    always_comb begin
        last_d = last_q;
        if (update_i) begin
            last_d = grant_o;
        end
    end

    // Last-grant register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= MST_IBUS;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/iob_bus_merge.sv
// Merges the CPU instruction and data native buses onto one memory port,
// one transaction at a time. The memory request is registered; the
// response is steered combinationally to the granted master only.
module iob_bus_merge
    import iob_bus_merge_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ibus_valid,
    input  logic [ADDR_W-1:0]   ibus_addr,
    input  logic [DATA_W-1:0]   ibus_wdata,
    input  logic [DATA_W/8-1:0] ibus_wstrb,
    output logic [DATA_W-1:0]   ibus_rdata,
    output logic                ibus_ready,
    input  logic                dbus_valid,
    input  logic [ADDR_W-1:0]   dbus_addr,
    input  logic [DATA_W-1:0]   dbus_wdata,
    input  logic [DATA_W/8-1:0] dbus_wstrb,
    output logic [DATA_W-1:0]   dbus_rdata,
    output logic                dbus_ready,
    output logic                mem_valid,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ready
);

    localparam int unsigned STRB_W = DATA_W / 8;

    state_e              state_q, state_d;
    logic                grant_q, grant_d;
    logic                valid_q, valid_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;

    logic arb_grant;
    logic arb_update;
    logic done;

    assign arb_update = (state_q == IDLE) && (ibus_valid || dbus_valid);
    assign done       = (state_q == BUSY) && mem_ready;

    iob_rr_arb2 u_arb (
        .clk        (clk),
        .rst        (rst),
        .ibus_req_i (ibus_valid),
        .dbus_req_i (dbus_valid),
        .update_i   (arb_update),
        .grant_o    (arb_grant)
    );

    // Next-state: capture the winner in IDLE, release on mem_ready in BUSY
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        if (state_q == IDLE) begin
            if (arb_update) begin
                state_d = BUSY;
                valid_d = 1'b1;
                grant_d = arb_grant;
                if (arb_grant == MST_DBUS) begin
                    addr_d  = dbus_addr;
                    wdata_d = dbus_wdata;
                    wstrb_d = dbus_wstrb;
                end else begin
                    addr_d  = ibus_addr;
                    wdata_d = ibus_wdata;
                    wstrb_d = ibus_wstrb;
                end
            end
        end else if (mem_ready) begin
            state_d = IDLE;
            valid_d = 1'b0;
            wstrb_d = '0;
        end
    end

    // FSM and registered memory request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= MST_IBUS;
            valid_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    assign mem_valid = valid_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;

    // Response goes to the granted master only; the other sees zeros
    always_comb begin
        ibus_ready = done && (grant_q == MST_IBUS);
        dbus_ready = done && (grant_q == MST_DBUS);
        ibus_rdata = ibus_ready ? mem_rdata : '0;
        dbus_rdata = dbus_ready ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_iob_bus_merge.sv
// Self-checking bench for iob_bus_merge: directed scenarios followed by a
// randomized run against a transaction-level reference model.
module tb_iob_bus_merge;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          ibus_valid;
    logic [AW-1:0] ibus_addr;
    logic [DW-1:0] ibus_wdata;
    logic [SW-1:0] ibus_wstrb;
    logic [DW-1:0] ibus_rdata;
    logic          ibus_ready;
    logic          dbus_valid;
    logic [AW-1:0] dbus_addr;
    logic [DW-1:0] dbus_wdata;
    logic [SW-1:0] dbus_wstrb;
    logic [DW-1:0] dbus_rdata;
    logic          dbus_ready;
    logic          mem_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [SW-1:0] mem_wstrb;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    iob_bus_merge #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ibus_valid (ibus_valid),
        .ibus_addr  (ibus_addr),
        .ibus_wdata (ibus_wdata),
        .ibus_wstrb (ibus_wstrb),
        .ibus_rdata (ibus_rdata),
        .ibus_ready (ibus_ready),
        .dbus_valid (dbus_valid),
        .dbus_addr  (dbus_addr),
        .dbus_wdata (dbus_wdata),
        .dbus_wstrb (dbus_wstrb),
        .dbus_rdata (dbus_rdata),
        .dbus_ready (dbus_ready),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    task automatic idle_inputs();
        ibus_valid = 1'b0; ibus_addr = '0; ibus_wdata = '0; ibus_wstrb = '0;
        dbus_valid = 1'b0; dbus_addr = '0; dbus_wdata = '0; dbus_wstrb = '0;
        mem_ready  = 1'b0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        dbus_valid = 1'b1; dbus_addr = 32'h44; dbus_wstrb = 4'hF;
        mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL rst_mem_valid got=%0b exp=0", mem_valid); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
        total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
        total++; if (mem_wstrb !== 4'h0) begin bad++; $display("FAIL rst_mem_wstrb got=%h exp=0", mem_wstrb); end
        total++; if (ibus_ready !== 1'b0) begin bad++; $display("FAIL rst_ibus_ready got=%0b exp=0", ibus_ready); end
        total++; if (dbus_ready !== 1'b0) begin bad++; $display("FAIL rst_dbus_ready got=%0b exp=0", dbus_ready); end
        total++; if (dbus_rdata !== 32'h0) begin bad++; $display("FAIL rst_dbus_rdata got=%h exp=0", dbus_rdata); end
        idle_inputs();
        rst = 1'b1;
    endtask

    task automatic test_dbus_read();
        int pulses = 0;
        @(negedge clk);
        dbus_valid = 1'b1; dbus_addr = 32'h100; dbus_wdata = '0; dbus_wstrb = '0;
        #1;
        total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL rd_early_valid got=%0b exp=0", mem_valid); end
        @(negedge clk); #1;
        total++; if (mem_valid !== 1'b1) begin bad++; $display("FAIL rd_latency got=%0b exp=1", mem_valid); end
        total++; if (mem_addr !== 32'h100) begin bad++; $display("FAIL rd_addr got=%h exp=100", mem_addr); end
        total++; if (mem_wstrb !== 4'h0) begin bad++; $display("FAIL rd_wstrb got=%h exp=0", mem_wstrb); end
        if (dbus_ready) pulses++;
        repeat (2) begin
            @(negedge clk); #1;
            if (dbus_ready) pulses++;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL rd_early_ready got=%0d exp=0", pulses); end
        @(negedge clk);
        mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        total++; if (dbus_ready !== 1'b1) begin bad++; $display("FAIL rd_dbus_ready got=%0b exp=1", dbus_ready); end
        total++; if (dbus_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_dbus_rdata got=%h exp=deadbeef", dbus_rdata); end
        total++; if (ibus_ready !== 1'b0) begin bad++; $display("FAIL rd_ibus_ready got=%0b exp=0", ibus_ready); end
        total++; if (ibus_rdata !== 32'h0) begin bad++; $display("FAIL rd_ibus_rdata got=%h exp=0", ibus_rdata); end
        @(negedge clk);
        idle_inputs();
        #1;
        total++; if (dbus_ready !== 1'b0) begin bad++; $display("FAIL rd_ready_one_cycle got=%0b exp=0", dbus_ready); end
        total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL rd_back_idle got=%0b exp=0", mem_valid); end
    endtask

    task automatic test_simultaneous();
        logic [AW-1:0] exp_order [4];
        exp_order[0] = 32'h500; exp_order[1] = 32'h400;
        exp_order[2] = 32'h504; exp_order[3] = 32'h404;
        do_reset();
        for (int unsigned pair = 0; pair < 2; pair++) begin
            @(negedge clk);
            ibus_valid = 1'b1; ibus_addr = exp_order[pair*2+1];
            dbus_valid = 1'b1; dbus_addr = exp_order[pair*2];
            for (int unsigned k = 0; k < 2; k++) begin
                @(negedge clk); #1;
                total++; if (mem_addr !== exp_order[pair*2+k]) begin bad++; $display("FAIL sim_order%0d got=%h exp=%h", pair*2+k, mem_addr, exp_order[pair*2+k]); end
                mem_ready = 1'b1; mem_rdata = 32'hA000_0000 + (pair*2+k);
                #1;
                total++; if (dbus_ready !== (k == 0)) begin bad++; $display("FAIL sim_dbus_ready%0d got=%0b exp=%0b", pair*2+k, dbus_ready, (k == 0)); end
                total++; if (ibus_ready !== (k == 1)) begin bad++; $display("FAIL sim_ibus_ready%0d got=%0b exp=%0b", pair*2+k, ibus_ready, (k == 1)); end
                @(negedge clk);
                mem_ready = 1'b0;
                if (k == 0) dbus_valid = 1'b0; else ibus_valid = 1'b0;
                #1;
                total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL sim_idle_gap%0d got=%0b exp=0", pair*2+k, mem_valid); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_write_stall();
        int pulses = 0;
        @(negedge clk);
        dbus_valid = 1'b1; dbus_addr = 32'h200; dbus_wdata = 32'h1234_5678; dbus_wstrb = 4'hF;
        @(negedge clk);
        for (int unsigned i = 0; i < 10; i++) begin
            #1;
            total++; if (mem_valid !== 1'b1) begin bad++; $display("FAIL wr_valid%0d got=%0b exp=1", i, mem_valid); end
            total++; if (mem_addr !== 32'h200) begin bad++; $display("FAIL wr_addr%0d got=%h exp=200", i, mem_addr); end
            total++; if (mem_wdata !== 32'h1234_5678) begin bad++; $display("FAIL wr_wdata%0d got=%h exp=12345678", i, mem_wdata); end
            total++; if (mem_wstrb !== 4'hF) begin bad++; $display("FAIL wr_wstrb%0d got=%h exp=f", i, mem_wstrb); end
            if (dbus_ready) pulses++;
            @(negedge clk);
        end
        mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
        #1;
        if (dbus_ready) pulses++;
        @(negedge clk);
        idle_inputs();
        #1;
        if (dbus_ready) pulses++;
        total++; if (pulses !== 1) begin bad++; $display("FAIL wr_ready_pulses got=%0d exp=1", pulses); end
        total++; if (mem_wstrb !== 4'h0) begin bad++; $display("FAIL wr_idle_wstrb got=%h exp=0", mem_wstrb); end
    endtask

    task automatic test_drop_valid();
        @(negedge clk);
        ibus_valid = 1'b1; ibus_addr = 32'h600; ibus_wstrb = 4'h0;
        @(negedge clk);
        ibus_valid = 1'b0;
        @(negedge clk);
        mem_ready = 1'b1; mem_rdata = 32'hCAFE_0001;
        #1;
        total++; if (ibus_ready !== 1'b1) begin bad++; $display("FAIL drop_ibus_ready got=%0b exp=1", ibus_ready); end
        total++; if (ibus_rdata !== 32'hCAFE_0001) begin bad++; $display("FAIL drop_ibus_rdata got=%h exp=cafe0001", ibus_rdata); end
        total++; if (dbus_ready !== 1'b0) begin bad++; $display("FAIL drop_dbus_ready got=%0b exp=0", dbus_ready); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_busy();
        @(negedge clk);
        ibus_valid = 1'b1; ibus_addr = 32'h300; ibus_wdata = 32'h55; ibus_wstrb = 4'h3;
        @(negedge clk); #1;
        total++; if (mem_valid !== 1'b1) begin bad++; $display("FAIL rb_busy got=%0b exp=1", mem_valid); end
        @(negedge clk); #2;
        rst = 1'b0;
        mem_ready = 1'b1; mem_rdata = 32'h7777_7777;
        #1;
        total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL rb_async_valid got=%0b exp=0", mem_valid); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rb_async_addr got=%h exp=0", mem_addr); end
        total++; if (ibus_ready !== 1'b0) begin bad++; $display("FAIL rb_ibus_ready got=%0b exp=0", ibus_ready); end
        total++; if (dbus_ready !== 1'b0) begin bad++; $display("FAIL rb_dbus_ready got=%0b exp=0", dbus_ready); end
        @(negedge clk);
        mem_ready = 1'b0;
        rst = 1'b1;
        ibus_addr = 32'h304; ibus_wstrb = 4'h0;
        @(negedge clk); #1;
        total++; if (mem_valid !== 1'b1) begin bad++; $display("FAIL rb_after_valid got=%0b exp=1", mem_valid); end
        total++; if (mem_addr !== 32'h304) begin bad++; $display("FAIL rb_after_addr got=%h exp=304", mem_addr); end
        mem_ready = 1'b1; mem_rdata = 32'hA5A5_0304;
        #1;
        total++; if (ibus_ready !== 1'b1) begin bad++; $display("FAIL rb_after_ready got=%0b exp=1", ibus_ready); end
        total++; if (ibus_rdata !== 32'hA5A5_0304) begin bad++; $display("FAIL rb_after_rdata got=%h exp=a5a50304", ibus_rdata); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_idle_ready();
        @(negedge clk);
        idle_inputs();
        mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
        #1;
        total++; if (ibus_ready !== 1'b0) begin bad++; $display("FAIL idle_ibus_ready got=%0b exp=0", ibus_ready); end
        total++; if (dbus_ready !== 1'b0) begin bad++; $display("FAIL idle_dbus_ready got=%0b exp=0", dbus_ready); end
        total++; if (dbus_rdata !== 32'h0) begin bad++; $display("FAIL idle_dbus_rdata got=%h exp=0", dbus_rdata); end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL idle_state got=%0b exp=0", mem_valid); end
    endtask

    // Random traffic: each master issues requests and holds valid until its
    // ready; the owner may drop valid once granted. The model tracks which
    // request owns the memory port, picking the master not granted last.
    task automatic test_random();
        int unsigned   n_req = 1000;
        logic [AW-1:0] r_addr  [2];
        logic [DW-1:0] r_wdata [2];
        logic [SW-1:0] r_wstrb [2];
        bit            pend [2];
        bit            vld  [2];
        int unsigned   others [2];
        bit            obs_rdy [2];
        logic [DW-1:0] obs_rd  [2];
        bit            exp_r;
        logic [DW-1:0] exp_rd;
        bit            m_busy  = 1'b0;
        int unsigned   m_owner = 0;
        int unsigned   m_last  = 0;
        int unsigned   lat = 0, issued = 0, done = 0, cyc = 0;

        for (int unsigned m = 0; m < 2; m++) begin
            pend[m] = 1'b0; vld[m] = 1'b0; others[m] = 0;
            r_addr[m] = '0; r_wdata[m] = '0; r_wstrb[m] = '0;
        end
        do_reset();
        while (done < n_req && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            for (int unsigned m = 0; m < 2; m++) begin
                if (!pend[m] && issued < n_req && ($urandom % 3) == 0) begin
                    pend[m] = 1'b1; vld[m] = 1'b1; others[m] = 0;
                    r_addr[m]  = AW'((m << 28) | (issued << 2));
                    r_wdata[m] = $urandom;
                    r_wstrb[m] = (($urandom % 2) == 0) ? SW'($urandom) : '0;
                    issued++;
                end else if (!pend[m]) begin
                    vld[m] = 1'b0;
                end else if (m_busy && m_owner == m && ($urandom % 6) == 0) begin
                    vld[m] = 1'b0;
                end
            end
            ibus_valid = vld[0]; ibus_addr = r_addr[0]; ibus_wdata = r_wdata[0]; ibus_wstrb = r_wstrb[0];
            dbus_valid = vld[1]; dbus_addr = r_addr[1]; dbus_wdata = r_wdata[1]; dbus_wstrb = r_wstrb[1];
            if (m_busy) begin
                if (lat == 0) begin
                    mem_ready = 1'b1; mem_rdata = $urandom;
                end else begin
                    mem_ready = 1'b0; lat--;
                end
            end else begin
                mem_ready = (($urandom % 5) == 0);
                mem_rdata = $urandom;
            end
            #1;
            obs_rdy[0] = ibus_ready; obs_rdy[1] = dbus_ready;
            obs_rd[0]  = ibus_rdata; obs_rd[1]  = dbus_rdata;
            total++; if (mem_valid !== m_busy) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", cyc, mem_valid, m_busy); end
            if (m_busy) begin
                total++; if (mem_addr !== r_addr[m_owner]) begin bad++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, mem_addr, r_addr[m_owner]); end
                total++; if (mem_wdata !== r_wdata[m_owner]) begin bad++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", cyc, mem_wdata, r_wdata[m_owner]); end
                total++; if (mem_wstrb !== r_wstrb[m_owner]) begin bad++; $display("FAIL rnd_wstrb cyc=%0d got=%h exp=%h", cyc, mem_wstrb, r_wstrb[m_owner]); end
            end else begin
                total++; if (mem_wstrb !== '0) begin bad++; $display("FAIL rnd_idle_wstrb cyc=%0d got=%h exp=0", cyc, mem_wstrb); end
            end
            for (int unsigned m = 0; m < 2; m++) begin
                exp_r  = m_busy && mem_ready && (m_owner == m);
                exp_rd = exp_r ? mem_rdata : '0;
                total++; if (obs_rdy[m] !== exp_r) begin bad++; $display("FAIL rnd_ready%0d cyc=%0d got=%0b exp=%0b", m, cyc, obs_rdy[m], exp_r); end
                total++; if (obs_rd[m] !== exp_rd) begin bad++; $display("FAIL rnd_rdata%0d cyc=%0d got=%h exp=%h", m, cyc, obs_rd[m], exp_rd); end
            end
            if (m_busy && mem_ready) begin
                for (int unsigned m = 0; m < 2; m++) begin
                    if (obs_rdy[m] && pend[1-m]) begin
                        others[1-m]++;
                        total++; if (others[1-m] > 1) begin bad++; $display("FAIL rnd_fair%0d cyc=%0d got=%0d exp<=1", 1-m, cyc, others[1-m]); end
                    end
                end
                pend[m_owner] = 1'b0;
                done++;
                m_busy = 1'b0;
            end else if (!m_busy && (vld[0] || vld[1])) begin
                if (vld[0] && vld[1]) m_owner = 1 - m_last;
                else m_owner = vld[1] ? 1 : 0;
                m_last = m_owner;
                m_busy = 1'b1;
                lat = $urandom % 4;
            end
        end
        total++; if (done != n_req) begin bad++; $display("FAIL rnd_completed got=%0d exp=%0d", done, n_req); end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_dbus_read();
        test_simultaneous();
        test_write_stall();
        test_drop_valid();
        test_reset_busy();
        test_idle_ready();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
